fetch_stage: RTL

- Instruction fetch stage; sits directly upstream of decode and supplies the 32-bit instruction word that decode slices for immediates and register fields.
- Holds the PC and issues word requests to instruction memory, with at most one request outstanding.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from later stages, flushing buffered and in-flight instructions.

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request, and a small
// instruction FIFO towards decode. Define FETCH_STALL_CNT_EN to add stall_cnt_o.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instruction_o,
  output logic [31:0] if_pc_o
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];
  logic [31:0]       fifo_instr_d [FIFO_DEPTH];
  logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]       fifo_pc_d    [FIFO_DEPTH];

  logic req_fire;
  logic push;
  logic pop;

  // Request is only offered when a slot is guaranteed for its response.
  assign imem_req_valid_o = (state_q == ST_REQ) && (count_q < DEPTH_CNT) &&
                            !redirect_valid_i && !rst_i;
  assign imem_req_addr_o  = rst_i ? RESET_PC : pc_q;
  assign if_valid_o       = (count_q != '0) && !rst_i;
  assign if_instruction_o = rst_i ? '0 : fifo_instr_q[rd_ptr_q];
  assign if_pc_o          = rst_i ? '0 : fifo_pc_q[rd_ptr_q];

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign pop      = if_valid_o && if_ready_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid_i) begin
          push    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & ~32'h3;
      push = 1'b0;
      if (state_q != ST_REQ) begin
        state_d = imem_resp_valid_i ? ST_REQ : ST_DRAIN;
      end
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;

    // Flush leaves the read pointer (and its entry) alone so head outputs hold.
    if (redirect_valid_i) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_resp_data_i;
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d               = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (if_ready_i && !if_valid_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
